hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage PipelineCPU. It watches register addresses and control bits in the ID, EX, MEM and WB stages. It generates stall, flush and bubble controls for PC, IF/ID and ID/EX, plus forwarding selects for the EX ALU operands and the ID branch comparator. A small FSM sequences multi-cycle load-use stalls and jalr redirects.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Producer writes a non-zero rd that equals the consumer's source register.
  function automatic logic reg_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-operand forwarding select: MEM result beats WB result, else regfile.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic [4:0] rd_mem,
  input  logic       regwrite_mem,
  input  logic       mem_block,
  input  logic [4:0] rd_wb,
  input  logic       regwrite_wb,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    // mem_block lets ID consumers skip a load still in MEM (data not ready yet)
    if (use_rs && !mem_block && reg_hit(regwrite_mem, rd_mem, rs)) sel = FWD_MEM;
    else if (use_rs && reg_hit(regwrite_wb, rd_wb, rs))            sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/bubble sequencing plus EX and ID forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  input  logic            use_rs1_id,
  input  logic            use_rs2_id,
  input  logic            is_branch_id,
  input  logic            taken_id,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_ex,
  input  logic [4:0]      rd_mem,
  input  logic [4:0]      rd_wb,
  input  logic            regwrite_ex,
  input  logic            regwrite_mem,
  input  logic            regwrite_wb,
  input  logic            memread_ex,
  input  logic            memread_mem,
  input  logic            jalr_ex,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a_ex,
  output logic [1:0]      fwd_b_ex,
  output logic [1:0]      fwd_a_id,
`ifdef HAZARD_PERF_EN
  output logic [1:0]      fwd_b_id,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
`else
  output logic [1:0]      fwd_b_id
`endif
);

  if (XLEN < 1) begin : g_bad_xlen
  end

  state_e     state_q, state_d;
  logic [1:0] need;
  logic       ex_hit, mem_hit;
  logic [1:0] sel_a_ex, sel_b_ex, sel_a_id, sel_b_id;

  fwd_sel u_fwd_a_ex (.rs(rs1_ex), .use_rs(1'b1), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
                      .mem_block(1'b0), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .sel(sel_a_ex));
  fwd_sel u_fwd_b_ex (.rs(rs2_ex), .use_rs(1'b1), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
                      .mem_block(1'b0), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .sel(sel_b_ex));
  fwd_sel u_fwd_a_id (.rs(rs1_id), .use_rs(use_rs1_id), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
                      .mem_block(memread_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .sel(sel_a_id));
  fwd_sel u_fwd_b_id (.rs(rs2_id), .use_rs(use_rs2_id), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
                      .mem_block(memread_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .sel(sel_b_id));

  assign fwd_a_ex = rst ? sel_a_ex : FWD_REG;
  assign fwd_b_ex = rst ? sel_b_ex : FWD_REG;
  assign fwd_a_id = rst ? sel_a_id : FWD_REG;
  assign fwd_b_id = rst ? sel_b_id : FWD_REG;

  // Stall length is the maximum over all producer/consumer terms.
  always_comb begin
    ex_hit  = (use_rs1_id && reg_hit(regwrite_ex, rd_ex, rs1_id)) ||
              (use_rs2_id && reg_hit(regwrite_ex, rd_ex, rs2_id));
    mem_hit = (use_rs1_id && reg_hit(regwrite_mem, rd_mem, rs1_id)) ||
              (use_rs2_id && reg_hit(regwrite_mem, rd_mem, rs2_id));
    need = 2'd0;
    if (ex_hit && !memread_ex && is_branch_id) need = 2'd1;
    if (mem_hit && memread_mem && is_branch_id) need = 2'd1;
    if (ex_hit && memread_ex) need = is_branch_id ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (!jalr_ex && state_q == RUN && need == 2'd2) state_d = STALL;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (jalr_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == STALL || need != 2'd0) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (taken_id) begin
      ifid_flush  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (pc_write ? XLEN'(0) : XLEN'(1));
    flush_cnt_d = flush_cnt_q + (ifid_flush ? XLEN'(1) : XLEN'(0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized checks of hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic use_rs1_id, use_rs2_id, is_branch_id, taken_id;
  logic regwrite_ex, regwrite_mem, regwrite_wb, memread_ex, memread_mem, jalr_ex;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id;
`ifdef HAZARD_PERF_EN
  logic [XLEN-1:0] stall_cnt, flush_cnt;
  logic [XLEN-1:0] exp_stall_cnt, exp_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int stall_left = 0;  // forced stall cycles still owed by the model

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .is_branch_id(is_branch_id), .taken_id(taken_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memread_ex(memread_ex), .memread_mem(memread_mem), .jalr_ex(jalr_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id),
`ifdef HAZARD_PERF_EN
    .fwd_b_id(fwd_b_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .fwd_b_id(fwd_b_id)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input logic wr, input logic [4:0] rd, input logic [4:0] rs, input logic u);
    return u && wr && rd != 0 && rd == rs;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] ex_sel(input logic [4:0] rs);
    if (dep(regwrite_mem, rd_mem, rs, 1'b1)) return 2'd1;
    if (dep(regwrite_wb, rd_wb, rs, 1'b1))   return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] id_sel(input logic [4:0] rs, input logic u);
    if (dep(regwrite_mem, rd_mem, rs, u) && !memread_mem) return 2'd1;
    if (dep(regwrite_wb, rd_wb, rs, u))                   return 2'd2;
    return 2'd0;
  endfunction

  task automatic idle();
    rs1_id = 0; rs2_id = 0; use_rs1_id = 0; use_rs2_id = 0; is_branch_id = 0; taken_id = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    memread_ex = 0; memread_mem = 0; jalr_ex = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int need, nxt;
    bit ex_m, mem_m, stall;
    logic e_pc, e_ifw, e_fl, e_bub;
    @(negedge clk);
    ex_m  = dep(regwrite_ex, rd_ex, rs1_id, use_rs1_id) || dep(regwrite_ex, rd_ex, rs2_id, use_rs2_id);
    mem_m = dep(regwrite_mem, rd_mem, rs1_id, use_rs1_id) || dep(regwrite_mem, rd_mem, rs2_id, use_rs2_id);
    need = 0;
    if (ex_m && memread_ex)                   need = max2(need, is_branch_id ? 2 : 1);
    if (ex_m && !memread_ex && is_branch_id)  need = max2(need, 1);
    if (mem_m && memread_mem && is_branch_id) need = max2(need, 1);
    e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; nxt = 0;
    if (!rst) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; stall_left = 0;
    end else if (jalr_ex) begin
      e_fl = 1; e_bub = 1;
    end else begin
      stall = (stall_left > 0) || (need > 0);
      if (stall) begin e_pc = 0; e_ifw = 0; e_bub = 1; end
      else if (taken_id) e_fl = 1;
      nxt = (stall_left > 0) ? stall_left - 1 : max2(need - 1, 0);
    end
    chk("pc_write", 32'(pc_write), 32'(e_pc));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    chk("fwd_a_ex", 32'(fwd_a_ex), rst ? 32'(ex_sel(rs1_ex)) : 32'd0);
    chk("fwd_b_ex", 32'(fwd_b_ex), rst ? 32'(ex_sel(rs2_ex)) : 32'd0);
    chk("fwd_a_id", 32'(fwd_a_id), rst ? 32'(id_sel(rs1_id, use_rs1_id)) : 32'd0);
    chk("fwd_b_id", 32'(fwd_b_id), rst ? 32'(id_sel(rs2_id, use_rs2_id)) : 32'd0);
`ifdef HAZARD_PERF_EN
    if (!rst) begin exp_stall_cnt = '0; exp_flush_cnt = '0; end
    chk("stall_cnt", stall_cnt, exp_stall_cnt);
    chk("flush_cnt", flush_cnt, exp_flush_cnt);
`endif
    @(posedge clk);
    stall_left = rst ? nxt : 0;
`ifdef HAZARD_PERF_EN
    if (rst) begin
      if (!e_pc) exp_stall_cnt++;
      if (e_fl)  exp_flush_cnt++;
    end
`endif
    #1;
  endtask

  initial begin
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = '0; exp_flush_cnt = '0;
`endif
    idle(); rst = 0;
    #2;
    repeat (2) step();
    rst = 1;
    step();

    // lw x5 ; add x6,x5,x5
    memread_ex = 1; regwrite_ex = 1; rd_ex = 5;
    rs1_id = 5; rs2_id = 5; use_rs1_id = 1; use_rs2_id = 1;
    step();
    chk("ld_alu_one_bubble", 32'(stall_left), 32'd0);
    idle(); regwrite_mem = 1; memread_mem = 1; rd_mem = 5;
    rs1_id = 5; rs2_id = 5; use_rs1_id = 1; use_rs2_id = 1;
    step();
    idle(); regwrite_wb = 1; rd_wb = 5; rs1_ex = 5; rs2_ex = 5;
    step();

    // lw x5 ; beq x5,x0
    idle(); memread_ex = 1; regwrite_ex = 1; rd_ex = 5;
    rs1_id = 5; use_rs1_id = 1; is_branch_id = 1;
    step();
    idle(); regwrite_mem = 1; memread_mem = 1; rd_mem = 5;
    rs1_id = 5; use_rs1_id = 1; is_branch_id = 1;
    step();
    idle(); regwrite_wb = 1; rd_wb = 5; rs1_id = 5; use_rs1_id = 1; is_branch_id = 1;
    step();

    // double hazard and x0
    idle(); rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1; rs1_ex = 7;
    step();
    idle(); rd_ex = 0; memread_ex = 1; regwrite_ex = 1; rs1_id = 0; use_rs1_id = 1; is_branch_id = 1;
    rd_mem = 0; regwrite_mem = 1; rd_wb = 0; regwrite_wb = 1;
    step();

    // jalr while in STALL, then a taken branch
    idle(); memread_ex = 1; regwrite_ex = 1; rd_ex = 3; rs2_id = 3; use_rs2_id = 1; is_branch_id = 1;
    step();
    idle(); jalr_ex = 1; taken_id = 1;
    step();
    idle(); taken_id = 1;
    step();

    // reset pulled low during STALL
    idle(); memread_ex = 1; regwrite_ex = 1; rd_ex = 9; rs1_id = 9; use_rs1_id = 1; is_branch_id = 1;
    step();
    idle(); rst = 0;
    #1;
    chk("async_rst_pc_write", 32'(pc_write), 32'd0);
    chk("async_rst_flush", 32'(ifid_flush), 32'd1);
    step();
    rst = 1;
    step();

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
      use_rs1_id = 1'($urandom); use_rs2_id = 1'($urandom);
      is_branch_id = 1'($urandom); taken_id = ($urandom_range(0, 3) == 0);
      regwrite_ex = 1'($urandom); regwrite_mem = 1'($urandom); regwrite_wb = 1'($urandom);
      memread_ex = 1'($urandom); memread_mem = 1'($urandom);
      jalr_ex = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
